// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: TMDS receive decode for one channel.
// Searches for symbol alignment by bit-slipping on control tokens, then emits
// decoded pixel bytes, control codes and data enable on the pixel clock.
// Ports:
//   iPCLK    - pixel clock (rising edge)
//   iRESETn  - asynchronous active-low reset
//   iDATA    - raw 10-bit deserialized word, bit 0 earliest, any alignment
//   oDATA    - decoded pixel byte, 0 during control periods
//   oCTL     - control code {C1,C0}, held through data periods
//   oDE      - data enable, data symbols while locked only
//   oLOCKED  - alignment lock
//   oSLIP    - current bit offset 0..9
module tmds_channel_decoder #(
   parameter int unsigned LOCK_COUNT     = 16,
   parameter int unsigned SEARCH_TIMEOUT = 2048,
   parameter int unsigned LOSS_TIMEOUT   = 4096
) (
   input  logic       iPCLK,
   input  logic       iRESETn,
   input  logic [9:0] iDATA,
   output logic [7:0] oDATA,
   output logic [1:0] oCTL,
   output logic       oDE,
   output logic       oLOCKED,
   output logic [3:0] oSLIP
);

   localparam int unsigned MAX_PARAM = (LOCK_COUNT > SEARCH_TIMEOUT) ?
      ((LOCK_COUNT > LOSS_TIMEOUT) ? LOCK_COUNT : LOSS_TIMEOUT) :
      ((SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT);
   localparam int unsigned CNT_W = $clog2(MAX_PARAM) + 1;

   localparam logic [9:0] TOK_00 = 10'b1101010100;
   localparam logic [9:0] TOK_01 = 10'b0010101011;
   localparam logic [9:0] TOK_10 = 10'b0101010100;
   localparam logic [9:0] TOK_11 = 10'b1010101011;

   typedef enum logic {SEARCH, LOCKED} state_t;

   state_t           rState, wStateNxt;
   logic [9:0]       rPREV;
   logic [9:0]       rSym;
   logic [CNT_W-1:0] rRunCnt, wRunNxt;
   logic [CNT_W-1:0] rTimer, wTimerNxt;
   logic [CNT_W-1:0] rLossCnt, wLossNxt;
   logic [1:0]       rFlush, wFlushNxt;
   logic [3:0]       wSlipNxt;
   logic [9:0]       wAligned;
   logic             wIsTok;
   logic [1:0]       wTokCode;
   logic [7:0]       wD;
   logic [7:0]       wDecData;
   logic             wDeNxt;

   // Aligned symbol taken from the 20-bit window {current, previous}
   always_comb begin
      wAligned = 10'({iDATA, rPREV} >> oSLIP);
   end

   // Control token recognition on the stage-1 symbol
   always_comb begin
      wIsTok   = 1'b1;
      wTokCode = 2'b00;
      case (rSym)
         TOK_00:  wTokCode = 2'b00;
         TOK_01:  wTokCode = 2'b01;
         TOK_10:  wTokCode = 2'b10;
         TOK_11:  wTokCode = 2'b11;
         default: wIsTok = 1'b0;
      endcase
   end

   // Data symbol decode: undo optional inversion, then XOR/XNOR chain
   always_comb begin
      wD          = rSym[9] ? ~rSym[7:0] : rSym[7:0];
      wDecData    = 8'h00;
      wDecData[0] = wD[0];
      for (int i = 1; i < 8; i++) begin
         wDecData[i] = rSym[8] ? (wD[i] ^ wD[i-1]) : ~(wD[i] ^ wD[i-1]);
      end
   end

   // Alignment FSM: next state, counters and slip offset
   always_comb begin
      wStateNxt = rState;
      wRunNxt   = rRunCnt;
      wTimerNxt = rTimer;
      wLossNxt  = rLossCnt;
      wFlushNxt = rFlush;
      wSlipNxt  = oSLIP;
      case (rState)
         SEARCH: begin
            // Lock takes priority over a slip in the same cycle
            if (wIsTok && (rFlush == 2'd0) && (rRunCnt == CNT_W'(LOCK_COUNT - 1))) begin
               wStateNxt = LOCKED;
               wRunNxt   = '0;
               wTimerNxt = '0;
               wLossNxt  = '0;
            end else if (rTimer == CNT_W'(SEARCH_TIMEOUT - 1)) begin
               wSlipNxt  = (oSLIP == 4'd9) ? 4'd0 : oSLIP + 4'd1;
               wRunNxt   = '0;
               wTimerNxt = '0;
               // Two symbols straddle the offset change; keep them out of the run
               wFlushNxt = 2'd2;
            end else begin
               wTimerNxt = rTimer + CNT_W'(1);
               if (rFlush != 2'd0) begin
                  wFlushNxt = rFlush - 2'd1;
                  wRunNxt   = '0;
               end else if (wIsTok) begin
                  wRunNxt = rRunCnt + CNT_W'(1);
               end else begin
                  wRunNxt = '0;
               end
            end
         end
         LOCKED: begin
            if (wIsTok) begin
               wLossNxt = '0;
            end else if (rLossCnt == CNT_W'(LOSS_TIMEOUT - 1)) begin
               wStateNxt = SEARCH;
               wLossNxt  = '0;
               wRunNxt   = '0;
               wTimerNxt = '0;
               wFlushNxt = 2'd0;
            end else begin
               wLossNxt = rLossCnt + CNT_W'(1);
            end
         end
         default: wStateNxt = SEARCH;
      endcase
      wDeNxt = (wStateNxt == LOCKED) && !wIsTok;
   end

   // FSM state register
   always_ff @(posedge iPCLK or negedge iRESETn) begin
      if (!iRESETn) rState <= SEARCH;
      else          rState <= wStateNxt;
   end

   // Window, two pipeline stages, counters and registered outputs
   always_ff @(posedge iPCLK or negedge iRESETn) begin
      if (!iRESETn) begin
         rPREV    <= '0;
         rSym     <= '0;
         rRunCnt  <= '0;
         rTimer   <= '0;
         rLossCnt <= '0;
         rFlush   <= '0;
         oSLIP    <= '0;
         oDATA    <= '0;
         oCTL     <= '0;
         oDE      <= 1'b0;
         oLOCKED  <= 1'b0;
      end else begin
         rPREV    <= iDATA;
         rSym     <= wAligned;
         rRunCnt  <= wRunNxt;
         rTimer   <= wTimerNxt;
         rLossCnt <= wLossNxt;
         rFlush   <= wFlushNxt;
         oSLIP    <= wSlipNxt;
         oLOCKED  <= (wStateNxt == LOCKED);
         oDE      <= wDeNxt;
         oDATA    <= wIsTok ? 8'h00 : wDecData;
         if (wIsTok) oCTL <= wTokCode;
      end
   end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: directed bench for tmds_channel_decoder with a
// cycle model of lock/slip behaviour and literal pins on key events.
module tb_tmds_channel_decoder;

   localparam int LOCK_COUNT     = 16;
   localparam int SEARCH_TIMEOUT = 2048;
   localparam int LOSS_TIMEOUT   = 4096;

   logic       iPCLK;
   logic       iRESETn;
   logic [9:0] iDATA;
   logic [7:0] oDATA;
   logic [1:0] oCTL;
   logic       oDE;
   logic       oLOCKED;
   logic [3:0] oSLIP;

   tmds_channel_decoder #(
      .LOCK_COUNT(LOCK_COUNT),
      .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
      .LOSS_TIMEOUT(LOSS_TIMEOUT)
   ) dut (
      .iPCLK(iPCLK),
      .iRESETn(iRESETn),
      .iDATA(iDATA),
      .oDATA(oDATA),
      .oCTL(oCTL),
      .oDE(oDE),
      .oLOCKED(oLOCKED),
      .oSLIP(oSLIP)
   );

   initial begin
      iPCLK = 1'b0;
      forever #5 iPCLK = ~iPCLK;
   end

   int checks = 0;
   int errors = 0;
   bit cmpEn  = 1'b0;

   // Model state
   logic [9:0] mPrev, mSym;
   int         mSlip, mStreak, mAge, mSilence, mFlush;
   bit         mLocked, mDe;
   logic [7:0] mData;
   logic [1:0] mCtl;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
      end
   endtask

   function automatic int tok_code(input logic [9:0] q);
      case (q)
         10'b1101010100: return 0;
         10'b0010101011: return 1;
         10'b0101010100: return 2;
         10'b1010101011: return 3;
         default:        return -1;
      endcase
   endfunction

   // Vector form of the decode: d ^ (d << 1), XNOR when q[8] is clear
   function automatic logic [7:0] tmds_dec(input logic [9:0] q);
      logic [7:0] d, x;
      d = q[9] ? ~q[7:0] : q[7:0];
      x = d ^ {d[6:0], 1'b0};
      if (!q[8]) x = x ^ 8'hFE;
      return x;
   endfunction

   function automatic logic [9:0] pat_sym(input int k);
      return ((k % 800) < 64) ? 10'h0AB : 10'h100;
   endfunction

   // Word n of the serial symbol stream preceded by sh zero bits
   function automatic logic [9:0] stream_word(input int n, input int sh);
      logic [9:0] r, s;
      int i;
      r = '0;
      for (int b = 0; b < 10; b++) begin
         i = 10 * n + b;
         if (i >= sh) begin
            s    = pat_sym((i - sh) / 10);
            r[b] = s[(i - sh) % 10];
         end
      end
      return r;
   endfunction

   task automatic model_reset();
      mPrev = '0; mSym = '0; mSlip = 0; mStreak = 0; mAge = 0;
      mSilence = 0; mFlush = 0; mLocked = 1'b0; mDe = 1'b0;
      mData = '0; mCtl = '0;
   endtask

   task automatic model_step(input logic [9:0] w);
      logic [19:0] win;
      logic [9:0]  nextSym;
      int          code;
      bit          tok;
      win     = {w, mPrev};
      nextSym = 10'(win >> mSlip);
      code    = tok_code(mSym);
      tok     = (code >= 0);
      if (mLocked) begin
         if (tok) mSilence = 0;
         else if (mSilence == LOSS_TIMEOUT - 1) begin
            mLocked = 1'b0; mSilence = 0; mStreak = 0; mAge = 0; mFlush = 0;
         end else mSilence++;
      end else begin
         if (tok && mFlush == 0 && mStreak == LOCK_COUNT - 1) begin
            mLocked = 1'b1; mStreak = 0; mAge = 0; mSilence = 0;
         end else if (mAge == SEARCH_TIMEOUT - 1) begin
            mSlip = (mSlip + 1) % 10; mStreak = 0; mAge = 0; mFlush = 2;
         end else begin
            mAge++;
            if (mFlush > 0) begin mFlush--; mStreak = 0; end
            else mStreak = tok ? mStreak + 1 : 0;
         end
      end
      mDe = mLocked && !tok;
      if (tok) begin mData = 8'h00; mCtl = 2'(code); end
      else mData = tmds_dec(mSym);
      mSym  = nextSym;
      mPrev = w;
   endtask

   task automatic tick(input logic [9:0] w);
      iDATA = w;
      @(posedge iPCLK);
      model_step(w);
      #1;
   endtask

   // Mid-stream asynchronous reset, checked before any clock edge
   task automatic do_reset();
      cmpEn = 1'b0;
      #2 iRESETn = 1'b0;
      #1;
      chk("rst_oDATA", 32'(oDATA), 0);
      chk("rst_oCTL", 32'(oCTL), 0);
      chk("rst_oDE", 32'(oDE), 0);
      chk("rst_oLOCKED", 32'(oLOCKED), 0);
      chk("rst_oSLIP", 32'(oSLIP), 0);
      model_reset();
      @(posedge iPCLK);
      @(posedge iPCLK);
      #3 iRESETn = 1'b1;
      cmpEn = 1'b1;
   endtask

   // Per-cycle comparison against the model
   always @(negedge iPCLK) begin
      if (cmpEn) begin
         chk("oDATA", 32'(oDATA), 32'(mData));
         chk("oCTL", 32'(oCTL), 32'(mCtl));
         chk("oDE", 32'(oDE), 32'(mDe));
         chk("oLOCKED", 32'(oLOCKED), 32'(mLocked));
         chk("oSLIP", 32'(oSLIP), 32'(mSlip));
      end
   end

   initial begin
      int nWord;
      int cnt;
      iRESETn = 1'b1;
      iDATA   = '0;
      #1 iRESETn = 1'b0;
      #1;
      chk("init_oDATA", 32'(oDATA), 0);
      chk("init_oCTL", 32'(oCTL), 0);
      chk("init_oDE", 32'(oDE), 0);
      chk("init_oLOCKED", 32'(oLOCKED), 0);
      chk("init_oSLIP", 32'(oSLIP), 0);
      model_reset();
      @(posedge iPCLK);
      #3 iRESETn = 1'b1;
      cmpEn = 1'b1;

      // Aligned lock at offset 0
      for (int j = 1; j <= 20; j++) begin
         tick(10'h354);
         if (j == 17) chk("lock_early", 32'(oLOCKED), 0);
         if (j == 18) begin
            chk("lock_rise", 32'(oLOCKED), 1);
            chk("lock_ctl", 32'(oCTL), 0);
         end
      end
      for (int j = 0; j < 3; j++) tick(10'h100);
      chk("d100_de", 32'(oDE), 1);
      chk("d100_data", 32'(oDATA), 32'h00);
      for (int j = 0; j < 3; j++) tick(10'h2FF);
      chk("d2ff_data", 32'(oDATA), 32'hFE);
      chk("d2ff_de", 32'(oDE), 1);
      for (int j = 0; j < 3; j++) tick(10'h2AB);
      chk("tok11_de", 32'(oDE), 0);
      chk("tok11_ctl", 32'(oCTL), 3);
      chk("tok11_data", 32'(oDATA), 0);

      // Loss of lock after LOSS_TIMEOUT data-only symbols
      for (int m = 1; m <= 4098; m++) begin
         tick(10'h100);
         if (m == 4097) begin
            chk("loss_hold", 32'(oLOCKED), 1);
            chk("loss_hold_de", 32'(oDE), 1);
         end
         if (m == 4098) begin
            chk("loss_fall", 32'(oLOCKED), 0);
            chk("loss_de", 32'(oDE), 0);
         end
      end
      for (int k = 1; k <= 20; k++) begin
         tick(10'h354);
         if (k == 17) chk("relock_early", 32'(oLOCKED), 0);
         if (k == 18) begin
            chk("relock_rise", 32'(oLOCKED), 1);
            chk("relock_slip", 32'(oSLIP), 0);
         end
      end

      // Misaligned stream at offset 3, preceded by a mid-stream reset
      for (int j = 0; j < 3; j++) tick(10'h2FF);
      do_reset();
      nWord = 0;
      for (int t = 1; t <= 6144 + 2048; t++) begin
         tick(stream_word(nWord, 3));
         nWord++;
         if ((t % 2048) == 2047 && t < 6144) chk("slip_before", 32'(oSLIP), 32'(t / 2048));
         if ((t % 2048) == 0 && t <= 6144) chk("slip_step", 32'(oSLIP), 32'(t / 2048));
         if (t > 6144 && oLOCKED) break;
      end
      chk("mis_locked", 32'(oLOCKED), 1);
      chk("mis_slip", 32'(oSLIP), 3);
      chk("mis_ctl", 32'(oCTL), 1);

      // Wrap: drive offset to 9, lock there, then re-shift to offset 0
      for (int j = 0; j < 3; j++) tick(10'h2FF);
      do_reset();
      cnt = 0;
      for (int t = 1; t <= 9 * 2048 + 4; t++) begin
         tick(10'h100);
         cnt = t;
         if (oSLIP == 4'd9) break;
      end
      chk("wrap_reach9", 32'(oSLIP), 9);
      chk("wrap_reach9_time", 32'(cnt), 9 * 2048);
      nWord = 0;
      for (int t = 0; t < 2100; t++) begin
         tick(stream_word(nWord, 9));
         nWord++;
         if (oLOCKED) break;
      end
      chk("wrap_lock9", 32'(oLOCKED), 1);
      chk("wrap_slip9", 32'(oSLIP), 9);
      for (int t = 0; t < 4200; t++) begin
         tick(stream_word(nWord, 0));
         nWord++;
         if (!oLOCKED) break;
      end
      chk("wrap_loss", 32'(oLOCKED), 0);
      chk("wrap_loss_slip", 32'(oSLIP), 9);
      cnt = 0;
      for (int t = 1; t <= 2100; t++) begin
         tick(stream_word(nWord, 0));
         nWord++;
         cnt = t;
         if (oSLIP == 4'd0) break;
      end
      chk("wrap_slip0", 32'(oSLIP), 0);
      chk("wrap_slip0_time", 32'(cnt), 2048);
      for (int t = 0; t < 2100; t++) begin
         tick(stream_word(nWord, 0));
         nWord++;
         if (oLOCKED) break;
      end
      chk("wrap_relock", 32'(oLOCKED), 1);
      chk("wrap_relock_slip", 32'(oSLIP), 0);

      cmpEn = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tmds_channel_decoder.md
# tmds_channel_decoder

Receive-side counterpart of the DVI output path: decodes one TMDS channel from 10-bit deserialized words on the pixel clock. It finds symbol alignment with a bit-slip search on control tokens, then outputs 8-bit pixel data, 2-bit control codes and data-enable. Three instances (blue, green, red) sit behind a pixel-clock deserializer and feed a video stream sink such as the arbiter's video input.

## Interface
- LOCK_COUNT, 16: consecutive control tokens at one offset required to lock.
- SEARCH_TIMEOUT, 2048: cycles at one offset without lock before slipping one bit.
- LOSS_TIMEOUT, 4096: cycles while locked without any control token before dropping lock.
- iPCLK  input  1  pixel clock; all logic on its rising edge.
- iRESETn  input  1  reset; asynchronous, active-low.
- iDATA  input  10  raw deserialized word; bit 0 is the earliest received bit; arbitrary alignment.
- oDATA  output  8  decoded pixel byte; 0 during control periods.
- oCTL  output  2  decoded control code {C1,C0}; holds its last value during data periods.
- oDE  output  1  data enable; 1 only for data symbols while locked.
- oLOCKED  output  1  alignment lock.
- oSLIP  output  4  current bit offset, 0..9.

## Operation
- Window: previous word rPREV is registered each cycle; the 20-bit concatenation {iDATA, rPREV} has rPREV in bits [9:0]; the aligned symbol is concat[oSLIP+9 : oSLIP].
- Control tokens (q[9:0]): 10'b1101010100 -> 00, 10'b0010101011 -> 01, 10'b0101010100 -> 10, 10'b1010101011 -> 11.
- Data decode (non-token symbol): d = q[9] ? ~q[7:0] : q[7:0]; out[0] = d[0]; for i = 1..7, out[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- FSM states:
  - SEARCH: run counter counts consecutive tokens and clears on any non-token. Reaching LOCK_COUNT goes to LOCKED. The timer counts cycles in SEARCH. At SEARCH_TIMEOUT-1:
    - oSLIP increments, wrapping 9 -> 0.
    - Run counter and timer clear.
    - The next two symbols are ignored for run counting (pipeline flush).
  - LOCKED: the loss timer clears on every token. When it reaches LOSS_TIMEOUT-1, go to SEARCH with counters cleared; oSLIP is unchanged, so the search restarts at the current offset.
- A lock event and a slip in the same cycle cannot occur: a lock suppresses the slip.
- In SEARCH, oDE is forced 0. oDATA and oCTL still decode, for debug.
- Counter widths: ceil(log2(max parameter)) + 1. No overflow is possible, because every counter clears at its terminal count.

## Timing
- Reset values:
  - oDATA = 0, oCTL = 0, oDE = 0, oLOCKED = 0, oSLIP = 0.
  - rPREV, the pipeline registers and all counters = 0.
  - FSM = SEARCH.
- Pipeline:
  - Stage 1 registers the aligned 10-bit symbol.
  - Stage 2 registers the decoded outputs.
  - A symbol complete in the window in cycle n appears on the outputs after the 2nd following rising edge (latency 2).
- oLOCKED rises on the edge after the LOCK_COUNT-th consecutive token reaches stage 1. oDE can assert from the next data symbol.
- oSLIP changes on the edge the timeout fires. Symbols formed with the new offset reach the outputs 2 edges later.
- A mid-operation reset asynchronously returns every output to its reset value within the reset assertion. The first decode after release is at latency 2.

## Test plan
- Reset: assert iRESETn=0 during a data stream -> all outputs 0 immediately, FSM in SEARCH, oSLIP=0.
- Aligned lock: at offset 0, send 20 words 10'b1101010100, then data 10'h100 -> oLOCKED=1 after the 16th token plus 1 edge, oCTL=00. The data word then gives oDE=1, oDATA=8'h00.
- Decode vector: locked, send 10'h2FF -> oDATA=8'hFE, oDE=1, 2 edges after entry. Send token 10'b1010101011 -> oDE=0, oCTL=11, oDATA=0.
- Misalignment: send the repeating pattern of 64 tokens (10'b0010101011) and 736 data words, with the serial stream shifted so the correct offset is 3 -> oSLIP steps 0,1,2,3 at 2048-cycle intervals. oLOCKED then rises with oSLIP=3 and oCTL=01.
- Wrap: correct offset 0 but the bench forces the start by holding lock off until oSLIP=9 (pattern shifted 9) -> lock at 9. Re-shift the stream to offset 0 -> loss after 4096 token-free cycles, then slip 9 -> 0 and re-lock at 0.
- Loss of lock: locked, then 4096 data-only words -> oLOCKED falls exactly at cycle 4096 and oDE goes to 0. Resuming tokens re-locks after 16 tokens without changing oSLIP.
